// File: rtl/decode.sv
// Instruction field decoder with scalar and vector register files.
// Reads are combinational and include a same-cycle bypass from the write port.
module decode #(
  parameter int unsigned DATA_WIDTH        = 19,
  parameter int unsigned VECTOR_SIZE       = 8,
  parameter int unsigned WIDTH             = 8,
  parameter int unsigned SCALAR_REGNUM     = 16,
  parameter int unsigned VECTOR_REGNUM     = 16,
  parameter int unsigned ADDRESS_WIDTH     = 4,
  parameter int unsigned OPCODE_WIDTH      = 5,
  parameter int unsigned INSTRUCTION_WIDTH = 32
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  writeEnableScalar,
  input  logic                                  writeEnableVector,
  input  logic [ADDRESS_WIDTH-1:0]              writeAddress,
  input  logic [DATA_WIDTH-1:0]                 writeScalarData,
  input  logic [VECTOR_SIZE-1:0][WIDTH-1:0]     writeVectorData,
  input  logic [INSTRUCTION_WIDTH-1:0]          instruction,
  output logic [DATA_WIDTH-1:0]                 reg1ScalarContent,
  output logic [DATA_WIDTH-1:0]                 reg2ScalarContent,
  output logic [DATA_WIDTH-1:0]                 inmediate,
  output logic [VECTOR_SIZE-1:0][WIDTH-1:0]     reg1VectorContent,
  output logic [VECTOR_SIZE-1:0][WIDTH-1:0]     reg2VectorContent,
  output logic [ADDRESS_WIDTH-1:0]              regDestinationAddress,
  output logic [ADDRESS_WIDTH-1:0]              reg1Address,
  output logic [ADDRESS_WIDTH-1:0]              reg2Address,
  output logic [OPCODE_WIDTH-1:0]               opcode
);

  localparam int unsigned DEST_MSB = INSTRUCTION_WIDTH - OPCODE_WIDTH - 1;
  localparam int unsigned SRC1_MSB = DEST_MSB - ADDRESS_WIDTH;
  localparam int unsigned SRC2_MSB = SRC1_MSB - ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]             scalar_q [SCALAR_REGNUM];
  logic [DATA_WIDTH-1:0]             scalar_d [SCALAR_REGNUM];
  logic [VECTOR_SIZE-1:0][WIDTH-1:0] vector_q [VECTOR_REGNUM];
  logic [VECTOR_SIZE-1:0][WIDTH-1:0] vector_d [VECTOR_REGNUM];

  logic bypass_s1, bypass_s2, bypass_v1, bypass_v2;

  // inmediate overlaps reg2Address; both are always driven
  always_comb begin
    opcode                = instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    regDestinationAddress = instruction[DEST_MSB -: ADDRESS_WIDTH];
    reg1Address           = instruction[SRC1_MSB -: ADDRESS_WIDTH];
    reg2Address           = instruction[SRC2_MSB -: ADDRESS_WIDTH];
    inmediate             = instruction[DATA_WIDTH-1:0];
  end

  // reset wins over any write in the same cycle
  always_comb begin
    scalar_d = scalar_q;
    vector_d = vector_q;
    if (reset) begin
      for (int unsigned i = 0; i < SCALAR_REGNUM; i++) scalar_d[i] = '0;
      for (int unsigned i = 0; i < VECTOR_REGNUM; i++) vector_d[i] = '0;
    end else begin
      if (writeEnableScalar) scalar_d[writeAddress] = writeScalarData;
      if (writeEnableVector) vector_d[writeAddress] = writeVectorData;
    end
  end

  always_ff @(posedge clock) begin
    scalar_q <= scalar_d;
    vector_q <= vector_d;
  end

  always_comb begin
    bypass_s1 = writeEnableScalar && !reset && (writeAddress == reg1Address);
    bypass_s2 = writeEnableScalar && !reset && (writeAddress == reg2Address);
    bypass_v1 = writeEnableVector && !reset && (writeAddress == reg1Address);
    bypass_v2 = writeEnableVector && !reset && (writeAddress == reg2Address);

    reg1ScalarContent = bypass_s1 ? writeScalarData : scalar_q[reg1Address];
    reg2ScalarContent = bypass_s2 ? writeScalarData : scalar_q[reg2Address];
    reg1VectorContent = bypass_v1 ? writeVectorData : vector_q[reg1Address];
    reg2VectorContent = bypass_v2 ? writeVectorData : vector_q[reg2Address];
  end

endmodule

// File: tb/tb_decode.sv
// Directed plus randomized checks of decode against a register-file model
// built from the architectural read/write/bypass/reset rules.
module tb_decode;

  logic              clock = 1'b0;
  logic              reset;
  logic              writeEnableScalar;
  logic              writeEnableVector;
  logic [3:0]        writeAddress;
  logic [18:0]       writeScalarData;
  logic [7:0][7:0]   writeVectorData;
  logic [31:0]       instruction;
  logic [18:0]       reg1ScalarContent;
  logic [18:0]       reg2ScalarContent;
  logic [18:0]       inmediate;
  logic [7:0][7:0]   reg1VectorContent;
  logic [7:0][7:0]   reg2VectorContent;
  logic [3:0]        regDestinationAddress;
  logic [3:0]        reg1Address;
  logic [3:0]        reg2Address;
  logic [4:0]        opcode;

  int checks = 0;
  int errors = 0;

  logic [18:0] sm [16];
  logic [63:0] vm [16];

  always #5 clock = ~clock;

  decode #(
    .DATA_WIDTH(19), .VECTOR_SIZE(8), .WIDTH(8), .SCALAR_REGNUM(16),
    .VECTOR_REGNUM(16), .ADDRESS_WIDTH(4), .OPCODE_WIDTH(5), .INSTRUCTION_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset),
    .writeEnableScalar(writeEnableScalar), .writeEnableVector(writeEnableVector),
    .writeAddress(writeAddress), .writeScalarData(writeScalarData),
    .writeVectorData(writeVectorData), .instruction(instruction),
    .reg1ScalarContent(reg1ScalarContent), .reg2ScalarContent(reg2ScalarContent),
    .inmediate(inmediate), .reg1VectorContent(reg1VectorContent),
    .reg2VectorContent(reg2VectorContent), .regDestinationAddress(regDestinationAddress),
    .reg1Address(reg1Address), .reg2Address(reg2Address), .opcode(opcode)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int r1, input int r2);
    return (op << 27) | (rd << 23) | (r1 << 19) | (r2 << 15);
  endfunction

  // Expected read of one file: pending write to the same index is visible unless in reset.
  function automatic logic [63:0] exp_s(input int ra);
    if (writeEnableScalar && !reset && writeAddress == ra) return 64'(writeScalarData);
    return 64'(sm[ra]);
  endfunction

  function automatic logic [63:0] exp_v(input int ra);
    if (writeEnableVector && !reset && writeAddress == ra) return writeVectorData;
    return vm[ra];
  endfunction

  task automatic check_outputs(input string tag);
    int r1, r2;
    r1 = (instruction >> 19) % 16;
    r2 = (instruction >> 15) % 16;
    chk({tag, ".opcode"}, 64'(opcode), 64'(instruction >> 27));
    chk({tag, ".dest"},   64'(regDestinationAddress), 64'((instruction >> 23) % 16));
    chk({tag, ".r1addr"}, 64'(reg1Address), 64'(r1));
    chk({tag, ".r2addr"}, 64'(reg2Address), 64'(r2));
    chk({tag, ".imm"},    64'(inmediate), 64'(instruction % (1 << 19)));
    chk({tag, ".s1"}, 64'(reg1ScalarContent), exp_s(r1));
    chk({tag, ".s2"}, 64'(reg2ScalarContent), exp_s(r2));
    chk({tag, ".v1"}, reg1VectorContent, exp_v(r1));
    chk({tag, ".v2"}, reg2VectorContent, exp_v(r2));
  endtask

  // Drive one cycle: check outputs before the edge, clock it, update the model.
  task automatic step(input string tag, input logic rst, input logic ws, input logic wv,
                      input int wa, input logic [18:0] sd, input logic [63:0] vd,
                      input logic [31:0] ins);
    reset = rst; writeEnableScalar = ws; writeEnableVector = wv;
    writeAddress = 4'(wa); writeScalarData = sd; writeVectorData = vd; instruction = ins;
    #1;
    check_outputs(tag);
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin sm[i] = '0; vm[i] = '0; end
    end else begin
      if (ws) sm[wa] = sd;
      if (wv) vm[wa] = vd;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; writeEnableScalar = 1'b0; writeEnableVector = 1'b0;
    writeAddress = '0; writeScalarData = '0; writeVectorData = '0;
    @(posedge clock);
    for (int i = 0; i < 16; i++) begin sm[i] = '0; vm[i] = '0; end
    #1;
  endtask

  initial begin
    logic [63:0] lanes;
    reset = 1'b1; writeEnableScalar = 1'b0; writeEnableVector = 1'b0;
    writeAddress = '0; writeScalarData = '0; writeVectorData = '0; instruction = '0;
    do_reset();

    // Field decoding examples
    instruction = 32'h1000_0003; #1;
    chk("ex1.opcode", 64'(opcode), 64'h02);
    chk("ex1.dest",   64'(regDestinationAddress), 64'h0);
    chk("ex1.imm",    64'(inmediate), 64'h3);
    instruction = 32'b00101_0001_0001_0101_000000000000000; #1;
    chk("ex2.opcode", 64'(opcode), 64'h05);
    chk("ex2.dest",   64'(regDestinationAddress), 64'h1);
    chk("ex2.r1addr", 64'(reg1Address), 64'h1);
    chk("ex2.r2addr", 64'(reg2Address), 64'h5);
    chk("ex2.imm",    64'(inmediate), 64'h28000);

    step("rst_state", 1'b1, 1'b0, 1'b0, 0, '0, '0, mk(0, 0, 0, 1));
    chk("rst.s1", 64'(reg1ScalarContent), 64'h0);
    chk("rst.v2", reg2VectorContent, 64'h0);

    // Scalar writes then read-back
    step("wr_s0", 1'b0, 1'b1, 1'b0, 0, 19'd3, '0, mk(0, 0, 0, 1));
    step("wr_s1", 1'b0, 1'b1, 1'b0, 1, 19'd2, '0, mk(0, 0, 0, 1));
    step("rd_s",  1'b0, 1'b0, 1'b0, 0, '0, '0, mk(0, 0, 0, 1));
    chk("scalar.r1", 64'(reg1ScalarContent), 64'd3);
    chk("scalar.r2", 64'(reg2ScalarContent), 64'd2);
    chk("scalar.v1", reg1VectorContent, 64'h0);
    chk("scalar.v2", reg2VectorContent, 64'h0);

    // Vector write with bypass before the edge
    lanes = {8'h05, 8'h05, 8'h05, 8'hFF, 8'h04, 8'h1F, 8'h0E, 8'h01};
    reset = 1'b0; writeEnableScalar = 1'b0; writeEnableVector = 1'b1;
    writeAddress = 4'd0; writeVectorData = lanes; instruction = mk(0, 0, 0, 1); #1;
    chk("vec.bypass", reg1VectorContent, lanes);
    chk("vec.bypass_lane4", 64'(reg1VectorContent[4]), 64'hFF);
    step("wr_v0", 1'b0, 1'b0, 1'b1, 0, '0, lanes, mk(0, 0, 0, 1));
    step("rd_v0", 1'b0, 1'b0, 1'b0, 0, '0, '0, mk(0, 0, 0, 0));
    chk("vec.after", reg1VectorContent, lanes);
    chk("vec.s0_kept", 64'(reg1ScalarContent), 64'd3);

    // Dual write at index 7, then reset with enables still high
    step("dual_wr", 1'b0, 1'b1, 1'b1, 7, 19'h5A5A5, 64'h0123_4567_89AB_CDEF, mk(1, 7, 7, 7));
    step("dual_rd", 1'b0, 1'b0, 1'b0, 0, '0, '0, mk(1, 7, 7, 0));
    chk("dual.s7", 64'(reg1ScalarContent), 64'h5A5A5);
    chk("dual.v7", reg1VectorContent, 64'h0123_4567_89AB_CDEF);
    step("rst_wr", 1'b1, 1'b1, 1'b1, 7, 19'h7FFFF, 64'hFFFF_FFFF_FFFF_FFFF, mk(1, 7, 7, 0));
    step("post_rst", 1'b0, 1'b0, 1'b0, 0, '0, '0, mk(1, 7, 7, 0));
    chk("rstwr.s7", 64'(reg1ScalarContent), 64'h0);
    chk("rstwr.v7", reg1VectorContent, 64'h0);
    chk("rstwr.s0", 64'(reg2ScalarContent), 64'h0);
    chk("rstwr.v0", reg2VectorContent, 64'h0);

    // Randomized traffic with occasional resets and forced address collisions
    for (int n = 0; n < 400; n++) begin
      int wa, r1, r2;
      logic [63:0] vd;
      wa = $urandom_range(0, 15);
      r1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom_range(0, 15);
      vd = {$urandom, $urandom};
      step("rand", ($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom), wa,
           19'($urandom), vd, mk($urandom_range(0, 31), $urandom_range(0, 15), r1, r2)
             | ($urandom % (1 << 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH 19 scalar word width; VECTOR_SIZE 8 lanes per vector; WIDTH 8 lane width; SCALAR_REGNUM 16 scalar registers; VECTOR_REGNUM 16 vector registers; ADDRESS_WIDTH 4 register address width; OPCODE_WIDTH 5 opcode width; INSTRUCTION_WIDTH 32 instruction width.
REQ-002 Single clock `clock`; reset is synchronous and active-high, port `reset`.
REQ-003 Ports, in this positional order (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- writeEnableScalar  in  1  scalar register file write enable
- writeEnableVector  in  1  vector register file write enable
- writeAddress  in  4  write register index, shared by both files
- writeScalarData  in  19  scalar write data
- writeVectorData  in  8x8 packed  vector write data, lane i = [i]
- instruction  in  32  instruction word
- reg1ScalarContent  out  19  scalar file read at reg1Address
- reg2ScalarContent  out  19  scalar file read at reg2Address
- inmediate  out  19  immediate field
- reg1VectorContent  out  8x8 packed  vector file read at reg1Address
- reg2VectorContent  out  8x8 packed  vector file read at reg2Address
- regDestinationAddress  out  4  destination register field
- reg1Address  out  4  source 1 field
- reg2Address  out  4  source 2 field
- opcode  out  5  opcode field

Function
REQ-004 Field extraction is purely combinational and opcode-independent: opcode = instruction[31:27]; regDestinationAddress = instruction[26:23]; reg1Address = instruction[22:19]; reg2Address = instruction[18:15]; inmediate = instruction[18:0], with no sign extension.
REQ-005 The inmediate and reg2Address fields overlap; both are always driven, and the consumer selects by opcode.
REQ-006 The scalar register file is 16 x 19 bits; the vector register file is 16 x (8 lanes x 8 bits); all registers, including index 0, are writable.
REQ-007 Writes are committed on the rising edge of clock: if writeEnableScalar = 1, scalar[writeAddress] <= writeScalarData; if writeEnableVector = 1, vector[writeAddress] <= writeVectorData.
REQ-008 When both enables are 1, both files are written at the same writeAddress in the same cycle, independently.
REQ-009 Reads are combinational: reg1*Content reflects the entry at reg1Address and reg2*Content the entry at reg2Address, for both files simultaneously.
REQ-010 Write-through bypass: if a write enable is 1, reset is 0, and writeAddress equals a read address, the matching content output shows the incoming write data in the same cycle, per file.
REQ-011 When reg1Address equals reg2Address, both outputs of a file present identical data.
REQ-012 The block has zero-cycle latency on every output; there is no handshake or stall.

Reset
REQ-013 On a rising edge with reset = 1, all 16 scalar and all 16 vector registers are cleared to 0; reset has priority over any write in that cycle.
REQ-014 Bypass is disabled while reset = 1; content outputs show stored values, which read 0 from the first reset edge on.
REQ-015 Field outputs (opcode, addresses, inmediate) follow instruction regardless of reset.
REQ-016 Register contents are undefined before the first reset edge; the bench issues a reset before checking contents.

Verification
REQ-017 instruction = 0x10000003 -> opcode 5'b00010, regDestinationAddress 0, inmediate 3.
REQ-018 instruction = 32'b00101_0001_0001_0101_000000000000000 -> opcode 5'b00101, regDestinationAddress 1, reg1Address 1, reg2Address 5, inmediate 0x28000.
REQ-019 Reset one edge, then write scalar reg 0 = 3 and reg 1 = 2 on successive edges; read with reg1Address = 0 and reg2Address = 1 -> reg1ScalarContent 3, reg2ScalarContent 2, both vector outputs 0.
REQ-020 Vector write to reg 0 of lanes {1, 0x0E, 0x1F, 0x04, 0xFF, 0x05, 0x05, 0x05} with writeEnableVector = 1 -> reg1VectorContent equal lane-for-lane before the edge (bypass) and after the edge; scalar reg 0 unchanged.
REQ-021 Both enables high, writeAddress 7 -> scalar and vector reg 7 both updated; assert reset with the enables still high -> all reads 0 after the edge, and the write is dropped.
